// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch redirect controller.
// Holds the redirect source encoding, the controller FSM states and the
// default reset / exception vectors.
package fetch_pkg;

    // Redirect source codes; a lower non-zero value means a higher priority
    typedef enum logic [2:0] {
        SRC_NONE    = 3'd0,
        SRC_BP_ERR  = 3'd1,
        SRC_EXC     = 3'd2,
        SRC_IRET    = 3'd3,
        SRC_JAL     = 3'd4,
        SRC_BP_PRED = 3'd5,
        SRC_RESET   = 3'd6
    } redirect_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] EXC_PC_DEFAULT   = 32'h0000_2000;

    // True when source a strictly outranks source b (SRC_NONE outranks nothing)
    function automatic logic higher_prio(input redirect_src_e a, input redirect_src_e b);
        return (a != SRC_NONE) && ((b == SRC_NONE) || (a < b));
    endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Fixed-priority redirect source selection and target computation.
// Priority: bp_error > exc > iret > jal > bp_taken. Purely combinational.
module redirect_prio_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_PC = EXC_PC_DEFAULT
) (
    input  logic          bp_error,
    input  logic [31:0]   bp_fix_pc,
    input  logic          exc_occured,
    input  logic          iret,
    input  logic [31:0]   exc_return_pc,
    input  logic          jal,
    input  logic [31:0]   jal_pc,
    input  logic          bp_taken,
    input  logic [31:0]   bp_pred_pc,
    output logic          win_valid,
    output redirect_src_e win_src,
    output logic [31:0]   win_pc
);

    localparam int N_SRC = 5;

    // Index 0 is the highest priority; index i maps to source code i+1
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] grant;
    logic [31:0]      tgt [N_SRC];

    assign req    = {bp_taken, jal, iret, exc_occured, bp_error};
    assign tgt[0] = bp_fix_pc;
    assign tgt[1] = EXC_PC;
    assign tgt[2] = exc_return_pc + 32'd4;
    assign tgt[3] = jal_pc + 32'd4;
    assign tgt[4] = bp_pred_pc;

    // One-hot grant: a request wins only if nothing above it is requesting
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_grant
            if (gi == 0) begin : g_first
                assign grant[gi] = req[gi];
            end else begin : g_rest
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    assign win_valid = |req;

    // Mux the granted source's code and target
    always_comb begin
        win_src = SRC_NONE;
        win_pc  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                win_src = redirect_src_e'(3'(i + 1));
                win_pc  = tgt[i];
            end
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates redirect sources, holds one pending
// redirect across pipeline stalls and opens a flush window after each issue.
// Optional feature macro FETCH_REDIRECT_CNT_EN adds a saturating 16-bit count
// of issued (non-reset) redirects on redirect_cnt_o.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_PC       = EXC_PC_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        stall_core_i,
    input  logic        bp_error_i,
    input  logic [31:0] bp_fix_pc_i,
    input  logic        exc_occured_i,
    input  logic        iret_i,
    input  logic [31:0] exc_return_pc_i,
    input  logic        jal_i,
    input  logic [31:0] jal_pc_i,
    input  logic        bp_taken_i,
    input  logic [31:0] bp_pred_pc_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [2:0]  redirect_src_o,
    output logic        flush_o,
    output logic        busy_o
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_cnt_o
`endif
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    fsm_state_e    state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic          pend_valid_reg, pend_valid_next;
    redirect_src_e pend_src_reg, pend_src_next;
    logic [31:0]   pend_pc_reg, pend_pc_next;
    logic          boot_reg, boot_next;

    logic          win_valid;
    redirect_src_e win_src;
    logic [31:0]   win_pc;

    logic          cand_valid;
    redirect_src_e cand_src;
    logic [31:0]   cand_pc;

    logic          issue;
    redirect_src_e issue_src;
    logic [31:0]   issue_pc;

    redirect_prio_sel #(
        .EXC_PC(EXC_PC)
    ) u_prio_sel (
        .bp_error      (bp_error_i),
        .bp_fix_pc     (bp_fix_pc_i),
        .exc_occured   (exc_occured_i),
        .iret          (iret_i),
        .exc_return_pc (exc_return_pc_i),
        .jal           (jal_i),
        .jal_pc        (jal_pc_i),
        .bp_taken      (bp_taken_i),
        .bp_pred_pc    (bp_pred_pc_i),
        .win_valid     (win_valid),
        .win_src       (win_src),
        .win_pc        (win_pc)
    );

    // Merge this cycle's winner with the pending entry: only a strictly
    // higher-priority winner replaces what is already held
    always_comb begin
        cand_valid = win_valid | pend_valid_reg;
        if (win_valid && (!pend_valid_reg || higher_prio(win_src, pend_src_reg))) begin
            cand_src = win_src;
            cand_pc  = win_pc;
        end else begin
            cand_src = pend_src_reg;
            cand_pc  = pend_pc_reg;
        end
    end

    // Next-state, pending-entry and issue decisions
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pend_valid_next = pend_valid_reg;
        pend_src_next   = pend_src_reg;
        pend_pc_next    = pend_pc_reg;
        boot_next       = boot_reg;
        issue           = 1'b0;
        issue_src       = SRC_NONE;
        issue_pc        = '0;

        if (boot_reg) begin
            // First cycle out of reset: the reset vector beats everything,
            // stall included; suppressed while reset is still held
            issue           = rsn_i;
            issue_src       = SRC_RESET;
            issue_pc        = RESET_PC;
            boot_next       = 1'b0;
            state_next      = ST_FLUSH;
            cnt_next        = FLUSH_LOAD;
            pend_valid_next = 1'b0;
            pend_src_next   = SRC_NONE;
            pend_pc_next    = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_PEND: begin
                    if (cand_valid) begin
                        if (!stall_core_i || cand_src == SRC_BP_ERR) begin
                            issue           = 1'b1;
                            issue_src       = cand_src;
                            issue_pc        = cand_pc;
                            pend_valid_next = 1'b0;
                            pend_src_next   = SRC_NONE;
                            pend_pc_next    = '0;
                            state_next      = ST_FLUSH;
                            cnt_next        = FLUSH_LOAD;
                        end else begin
                            pend_valid_next = 1'b1;
                            pend_src_next   = cand_src;
                            pend_pc_next    = cand_pc;
                            state_next      = ST_PEND;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (win_valid && win_src == SRC_BP_ERR) begin
                        // A mispredict restarts the window and supersedes
                        // anything waiting
                        issue           = 1'b1;
                        issue_src       = win_src;
                        issue_pc        = win_pc;
                        pend_valid_next = 1'b0;
                        pend_src_next   = SRC_NONE;
                        pend_pc_next    = '0;
                        cnt_next        = FLUSH_LOAD;
                    end else begin
                        if (cand_valid) begin
                            pend_valid_next = 1'b1;
                            pend_src_next   = cand_src;
                            pend_pc_next    = cand_pc;
                        end
                        cnt_next = cnt_reg - 3'd1;
                        if (cnt_reg <= 3'd1) begin
                            state_next = cand_valid ? ST_PEND : ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and pending-entry registers
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_src_reg   <= SRC_NONE;
            pend_pc_reg    <= '0;
            boot_reg       <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_src_reg   <= pend_src_next;
            pend_pc_reg    <= pend_pc_next;
            boot_reg       <= boot_next;
        end
    end

    assign redirect_valid_o = issue;
    assign redirect_pc_o    = issue ? issue_pc : '0;
    assign redirect_src_o   = issue ? 3'(issue_src) : 3'd0;
    assign flush_o          = (state_reg == ST_FLUSH);
    assign busy_o           = (state_reg != ST_IDLE);

`ifdef FETCH_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt_reg;

    // Saturating count of issued redirects, reset vector excluded
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            redirect_cnt_reg <= '0;
        end else if (issue && issue_src != SRC_RESET && redirect_cnt_reg != 16'hFFFF) begin
            redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
        end
    end

    assign redirect_cnt_o = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed vector table, then randomized
// stimulus checked against a behavioural model of the redirect rules.
module tb_fetch_redirect_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rsn;
    logic        stall;
    logic        bpe;
    logic [31:0] fix_pc;
    logic        exc;
    logic        iret;
    logic [31:0] ret_pc;
    logic        jal;
    logic [31:0] jal_pc;
    logic        bpt;
    logic [31:0] pred_pc;
    logic        rvalid;
    logic [31:0] rpc;
    logic [2:0]  rsrc;
    logic        flush;
    logic        busy;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [15:0] rcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_redirect_ctrl #(
        .RESET_PC     (32'h0000_1000),
        .EXC_PC       (32'h0000_2000),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk_i            (clk),
        .rsn_i            (rsn),
        .stall_core_i     (stall),
        .bp_error_i       (bpe),
        .bp_fix_pc_i      (fix_pc),
        .exc_occured_i    (exc),
        .iret_i           (iret),
        .exc_return_pc_i  (ret_pc),
        .jal_i            (jal),
        .jal_pc_i         (jal_pc),
        .bp_taken_i       (bpt),
        .bp_pred_pc_i     (pred_pc),
        .redirect_valid_o (rvalid),
        .redirect_pc_o    (rpc),
        .redirect_src_o   (rsrc),
        .flush_o          (flush),
        .busy_o           (busy)
`ifdef FETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt_o   (rcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        rsn;
        logic        stall;
        logic [4:0]  req;   // {bp_error, exc, iret, jal, bp_taken}
        logic [31:0] pc_in; // drives every PC input of the row
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  esrc;
        logic        ef;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input string nm, input logic r, input logic st, input logic [4:0] rq,
                       input logic [31:0] pin, input logic ev, input logic [31:0] epc,
                       input logic [2:0] es, input logic ef, input logic eb);
        vec_t v;
        v.name = nm; v.rsn = r; v.stall = st; v.req = rq; v.pc_in = pin;
        v.ev = ev; v.epc = epc; v.esrc = es; v.ef = ef; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic idle_rows(input string nm, input logic st, input int n_flush);
        for (int k = 0; k < n_flush; k++) row(nm, 1, st, 5'b0, 32'h0, 0, 32'h0, 3'd0, 1, 1);
        row({nm, "_idle"}, 1, st, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
    endtask

    task automatic check(input string nm, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual {v,pc,src,fl,busy}=%h required %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] pc;
    } ent_t;

    ent_t m_pend[$];
    int   m_flush_left;
    bit   m_boot;
    int   m_cnt;

    // Expected outputs for the current cycle's inputs; advances the model
    // to the state it will hold after the next clock edge
    task automatic model_step(output logic [37:0] exp);
        ent_t reqs[$];
        ent_t e;
        logic ev;
        ent_t iss;
        logic ef;
        logic eb;
        ev  = 1'b0;
        iss = '0;
        if (!rsn) begin
            m_boot = 1'b1; m_flush_left = 0; m_pend.delete(); m_cnt = 0;
            exp = '0;
            return;
        end
        ef = (m_flush_left > 0);
        eb = (m_flush_left > 0) || (m_pend.size() > 0);
        if (bpe)  begin e = {3'd1, fix_pc};             reqs.push_back(e); end
        if (exc)  begin e = {3'd2, 32'h0000_2000};      reqs.push_back(e); end
        if (iret) begin e = {3'd3, ret_pc + 32'd4};     reqs.push_back(e); end
        if (jal)  begin e = {3'd4, jal_pc + 32'd4};     reqs.push_back(e); end
        if (bpt)  begin e = {3'd5, pred_pc};            reqs.push_back(e); end
        if (m_boot) begin
            ev = 1'b1; iss = {3'd6, 32'h0000_1000};
            m_boot = 1'b0; m_flush_left = FC;
        end else if (m_flush_left > 0 && reqs.size() > 0 && reqs[0].src == 3'd1) begin
            ev = 1'b1; iss = reqs[0];
            m_pend.delete(); m_flush_left = FC;
        end else begin
            if (reqs.size() > 0 && (m_pend.size() == 0 || reqs[0].src < m_pend[0].src)) begin
                m_pend.delete();
                m_pend.push_back(reqs[0]);
            end
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_pend.size() > 0 && (!stall || m_pend[0].src == 3'd1)) begin
                ev = 1'b1; iss = m_pend[0];
                m_pend.delete(); m_flush_left = FC;
            end
        end
        if (ev && iss.src != 3'd6 && m_cnt < 65535) m_cnt++;
        exp = {ev, iss.pc, iss.src, ef, eb};
    endtask

    task automatic drive(input logic r, input logic st, input logic [4:0] rq, input logic [31:0] pin);
        rsn = r; stall = st;
        {bpe, exc, iret, jal, bpt} = rq;
        fix_pc = pin; ret_pc = pin; jal_pc = pin; pred_pc = pin;
    endtask

    initial begin
        logic [37:0] exp;
        int rst_left;
        drive(0, 0, 5'b0, 32'h0);

        // Vector table: one row per cycle
        row("rst_hold", 0, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("boot",     1, 0, 5'b0, 32'h0, 1, 32'h1000, 3'd6, 0, 0);
        idle_rows("boot_fl", 0, 2);
        row("jal",      1, 0, 5'b00010, 32'h1100, 1, 32'h1104, 3'd4, 0, 0);
        idle_rows("jal_fl", 0, 2);
        row("stall_jal",  1, 1, 5'b00010, 32'h1100, 0, 32'h0, 3'd0, 0, 0);
        row("stall_exc",  1, 1, 5'b01010, 32'h1100, 0, 32'h0, 3'd0, 0, 1);
        row("stall_jal3", 1, 1, 5'b00010, 32'h1100, 0, 32'h0, 3'd0, 0, 1);
        row("exc_issue",  1, 0, 5'b0, 32'h0, 1, 32'h2000, 3'd2, 0, 1);
        idle_rows("exc_fl", 0, 2);
        row("stall_iret", 1, 1, 5'b00100, 32'h1200, 0, 32'h0, 3'd0, 0, 0);
        row("bperr_pend", 1, 1, 5'b10000, 32'h1040, 1, 32'h1040, 3'd1, 0, 1);
        idle_rows("bpe_fl", 1, 2);
        row("no_iret",    1, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("jal2",       1, 0, 5'b00010, 32'h3000, 1, 32'h3004, 3'd4, 0, 0);
        row("bperr_fl1",  1, 0, 5'b10000, 32'h1080, 1, 32'h1080, 3'd1, 1, 1);
        idle_rows("ext_fl", 0, 2);
        row("bp_pred",    1, 0, 5'b00001, 32'h4444, 1, 32'h4444, 3'd5, 0, 0);
        idle_rows("pred_fl", 0, 2);
        row("iret_wrap",  1, 0, 5'b00100, 32'hFFFF_FFFE, 1, 32'h2, 3'd3, 0, 0);
        idle_rows("wrap_fl", 0, 2);
        row("jal_zero",   1, 0, 5'b00010, 32'h0, 1, 32'h4, 3'd4, 0, 0);
        row("jz_fl1",     1, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 1, 1);
        row("rst_mid_fl", 0, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("rst_hold2",  0, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("boot2",      1, 0, 5'b0, 32'h0, 1, 32'h1000, 3'd6, 0, 0);
        idle_rows("boot2_fl", 0, 2);
        row("stall_jal_b",  1, 1, 5'b00010, 32'h1100, 0, 32'h0, 3'd0, 0, 0);
        row("pend_hold",    1, 1, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 1);
        row("rst_mid_pend", 0, 1, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("boot_stall",   1, 1, 5'b0, 32'h0, 1, 32'h1000, 3'd6, 0, 0);
        idle_rows("bs_fl", 1, 2);
        row("no_pend",      1, 0, 5'b0, 32'h0, 0, 32'h0, 3'd0, 0, 0);
        row("all_src",      1, 0, 5'b11111, 32'h5000, 1, 32'h5000, 3'd1, 0, 0);
        idle_rows("all_fl", 0, 2);
        row("four_src",     1, 0, 5'b01111, 32'h5000, 1, 32'h2000, 3'd2, 0, 0);
        idle_rows("four_fl", 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rsn, vecs[i].stall, vecs[i].req, vecs[i].pc_in);
            @(negedge clk);
            $display("vec %0d %s: valid=%b pc=%h src=%0d flush=%b busy=%b",
                     i, vecs[i].name, rvalid, rpc, rsrc, flush, busy);
            check(vecs[i].name, {rvalid, rpc, rsrc, flush, busy},
                  {vecs[i].ev, vecs[i].epc, vecs[i].esrc, vecs[i].ef, vecs[i].eb});
        end

        // Randomized phase against the reference model
        rst_left = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rst_left > 0) begin
                rst_left--;
                rsn = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                rsn = 1'b0;
                rst_left = int'($urandom_range(0, 1));
            end else begin
                rsn = 1'b1;
            end
            stall   = ($urandom_range(0, 9) < 4);
            bpe     = ($urandom_range(0, 19) == 0);
            exc     = ($urandom_range(0, 9) == 0);
            iret    = ($urandom_range(0, 9) == 0);
            jal     = ($urandom_range(0, 6) == 0);
            bpt     = ($urandom_range(0, 6) == 0);
            fix_pc  = $urandom;
            ret_pc  = $urandom;
            jal_pc  = $urandom;
            pred_pc = $urandom;
            @(negedge clk);
`ifdef FETCH_REDIRECT_CNT_EN
            if (rsn) check("rand_cnt", 38'(rcnt), 38'(m_cnt));
`endif
            model_step(exp);
            if (rvalid)
                $display("rand %0d: redirect pc=%h src=%0d", c, rpc, rsrc);
            check("rand", {rvalid, rpc, rsrc, flush, busy}, exp);
        end

`ifdef FETCH_REDIRECT_CNT_EN
        // Saturation: a mispredict every cycle issues one redirect per cycle
        @(posedge clk); #1;
        drive(0, 0, 5'b0, 32'h0);
        @(posedge clk); #1;
        drive(1, 0, 5'b0, 32'h0);
        for (int k = 0; k < FC + 2; k++) @(posedge clk);
        #1;
        check("cnt_cleared", 38'(rcnt), 38'd0);
        drive(1, 0, 5'b10000, 32'h1234);
        for (int k = 0; k < 65537; k++) @(posedge clk);
        #1;
        drive(1, 0, 5'b0, 32'h0);
        @(negedge clk);
        $display("sat: redirect_cnt=%h", rcnt);
        check("cnt_saturate", 38'(rcnt), 38'h0_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1000, the PC driven after reset.
REQ-002 SHALL have parameter EXC_PC, default 32'h2000, the exception handler target.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7, the length of the flush window after a redirect.
REQ-004 SHALL have ports, clock and reset first: clk_i in 1, the clock; rsn_i in 1, reset, asynchronous, active-low.
REQ-005 SHALL have port stall_core_i in 1, pipeline stall.
REQ-006 SHALL have ports bp_error_i in 1 and bp_fix_pc_i in 32, branch mispredict and corrected PC.
REQ-007 SHALL have port exc_occured_i in 1, exception raised.
REQ-008 SHALL have ports iret_i in 1 and exc_return_pc_i in 32, return from exception.
REQ-009 SHALL have ports jal_i in 1 and jal_pc_i in 32, jump and link.
REQ-010 SHALL have ports bp_taken_i in 1 and bp_pred_pc_i in 32, predicted-taken branch.
REQ-011 SHALL have ports redirect_valid_o out 1, redirect_pc_o out 32 and redirect_src_o out 3: redirect strobe, target and source (0 none, 1 bp_err, 2 exc, 3 iret, 4 jal, 5 bp_pred, 6 reset).
REQ-012 SHALL have ports flush_o out 1, kill younger fetched instructions, and busy_o out 1, state is not IDLE.

Function
REQ-013 SHALL use fixed source priority bp_error > exc > iret > jal > bp_taken; only the winner is considered each cycle.
REQ-014 SHALL compute targets as bp_fix_pc_i, EXC_PC, exc_return_pc_i+4, jal_pc_i+4 and bp_pred_pc_i, all modulo 2^32.
REQ-015 SHALL use FSM states IDLE, PEND and FLUSH.
REQ-016 IDLE with a winner and no stall: redirect_valid_o=1 in the same cycle (combinational), then go to FLUSH.
REQ-017 IDLE with a winner while stalled: latch source and target into a one-entry pending register and go to PEND; except bp_error, which ignores stall and issues immediately.
REQ-018 PEND: a new strictly-higher-priority winner overwrites the pending entry; an equal or lower-priority winner is dropped.
REQ-019 PEND: issue the pending entry on the first cycle stall_core_i=0, then go to FLUSH.
REQ-020 PEND: bp_error issues immediately regardless of stall and discards the pending entry.
REQ-021 FLUSH: flush_o=1 for exactly FLUSH_CYCLES cycles, counted by a 3-bit down-counter, then return to IDLE, or to PEND if an entry is pending.
REQ-022 FLUSH: bp_error issues immediately and restarts the counter; other winners are latched per REQ-018.
REQ-023 SHALL hold redirect_valid_o high for exactly one cycle per issue; redirect_pc_o and redirect_src_o are valid only while it is high and 0 otherwise.

Reset
REQ-024 rsn_i=0 SHALL asynchronously force state IDLE, clear the pending entry and counter, and zero flush_o and busy_o.
REQ-025 On the first clock with rsn_i=1, SHALL issue redirect_valid_o=1, redirect_pc_o=RESET_PC, src=6, ignoring stall, then go to FLUSH.
REQ-026 Reset asserted mid-FLUSH or mid-PEND SHALL abort it with no redirect issued.

Configuration
REQ-027 With FETCH_REDIRECT_CNT_EN defined, SHALL add port redirect_cnt_o out 16, a saturating count of issued redirects excluding reset, cleared by reset and held at 16'hFFFF.
REQ-028 Without FETCH_REDIRECT_CNT_EN, SHALL have neither the port nor the counter logic.

Structure
REQ-029 SHALL place the source encoding enum, the FSM state enum and the RESET_PC/EXC_PC defaults in shared package fetch_pkg.
REQ-030 SHALL put the priority selection and target computation in one combinational sub-module, redirect_prio_sel.

Verification
REQ-031 Reset release -> next cycle valid=1, pc=32'h1000, src=6; flush_o high for 2 cycles.
REQ-032 jal_i=1, jal_pc_i=32'h1100, no stall -> valid=1, pc=32'h1104, src=4; then flush_o for 2 cycles.
REQ-033 jal_i=1 while stalled 3 cycles, then exc_occured_i in stall cycle 2 -> one redirect after the stall drops: pc=32'h2000, src=2.
REQ-034 Stalled with pending iret, bp_error_i=1, bp_fix_pc_i=32'h1040 -> immediate pc=32'h1040, src=1; the pending iret is discarded.
REQ-035 bp_error_i in flush cycle 1 -> new redirect issued and flush_o extended to 3 cycles total.
REQ-036 With FETCH_REDIRECT_CNT_EN, 65537 jal redirects -> redirect_cnt_o=16'hFFFF.
